// File: rtl/keypad_pkg.sv
// Shared types for the matrix-keypad scanner: per-frame scan result,
// stable-key state and the key-code width helper.
package keypad_pkg;

  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_res_e;

  typedef enum logic {ST_IDLE, ST_HELD} state_e;

  function automatic int key_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_n_if.sv
// Key-event handshake: the scanner drives code/valid, the consumer drives ready.
interface keypad_scanner_n_if #(
  parameter int KEY_W = 4
) ();

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);

endinterface

// File: rtl/key_event_buf.sv
// One-entry valid/ready event register; a push that finds the entry occupied
// and not being drained is dropped and latches the sticky overflow flag.
module key_event_buf #(
  parameter int KEY_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [KEY_W-1:0]   push_code,
  keypad_scanner_n_if.master bus,
  output logic               overflow
);

  logic [KEY_W-1:0] code_reg;
  logic             valid_reg;
  logic             overflow_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      // A push coinciding with acceptance reuses the slot without a gap.
      if (push && (!valid_reg || bus.key_ready)) begin
        code_reg  <= push_code;
        valid_reg <= 1'b1;
      end else if (push) begin
        overflow_reg <= 1'b1;
      end else if (valid_reg && bus.key_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.key_code  = code_reg;
  assign bus.key_valid = valid_reg;
  assign overflow      = overflow_reg;

endmodule

// File: rtl/keypad_scanner_n.sv
// Matrix-keypad scanner: one-cold column drive, frame-level debounce with
// ghost rejection, stable-key FSM with optional auto-repeat.
module keypad_scanner_n #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DLY     = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ROWS-1:0]    rows,
  output logic [COLS-1:0]    cols,
  keypad_scanner_n_if.master key_bus,
  output logic               key_held,
  output logic               overflow
);
  import keypad_pkg::*;

  localparam int KEY_W   = key_w(ROWS, COLS);
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int WIN_W   = $clog2(SCAN_DIV);
  localparam int RUN_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef struct packed {
    frame_res_e       kind;
    logic [KEY_W-1:0] code;
  } frame_t;

  logic [ROWS-1:0]  rows_meta_reg, rows_sync_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [COL_W-1:0] col_idx_reg;
  logic [1:0]       acc_cnt_reg;
  logic [KEY_W-1:0] acc_code_reg;
  frame_t           prev_res_reg;
  logic [RUN_W-1:0] run_cnt_reg;

  logic             sample_tick, frame_tick;
  logic [1:0]       col_cnt, sum_cnt;
  logic [2:0]       tot_cnt;
  logic [ROW_W-1:0] col_row;
  logic [KEY_W-1:0] col_code, sum_code;
  frame_t           frame_res;
  logic             same_res, accept;
  logic [RUN_W-1:0] run_next;

  state_e           state_reg, state_next;
  logic [KEY_W-1:0] held_code_reg, held_code_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next, rep_limit;
  logic             rep_first_reg, rep_first_next;
  logic             ev_push;
  logic [KEY_W-1:0] ev_code;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
    assign cols[gi] = (col_idx_reg != COL_W'(gi));
  end

  assign sample_tick = (win_cnt_reg == WIN_W'(SCAN_DIV - 1));
  assign frame_tick  = sample_tick && (col_idx_reg == COL_W'(COLS - 1));

  // Low-bit count saturates at 2: anything beyond one key is a ghost frame.
  always_comb begin
    col_cnt = 2'd0;
    col_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!rows_sync_reg[r]) begin
        if (col_cnt == 2'd0) col_row = ROW_W'(r);
        if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
      end
    end
    col_code = KEY_W'(int'(col_row) * COLS + int'(col_idx_reg));
    tot_cnt  = {1'b0, acc_cnt_reg} + {1'b0, col_cnt};
    sum_cnt  = (tot_cnt >= 3'd2) ? 2'd2 : tot_cnt[1:0];
    sum_code = (acc_cnt_reg != 2'd0) ? acc_code_reg : col_code;
    frame_res.kind = (sum_cnt == 2'd0) ? FR_NONE :
                     (sum_cnt == 2'd1) ? FR_SINGLE : FR_MULTI;
    frame_res.code = (sum_cnt == 2'd1) ? sum_code : '0;
  end

  assign same_res = (frame_res == prev_res_reg);
  assign run_next = !same_res ? RUN_W'(1) :
                    (run_cnt_reg == RUN_W'(DEBOUNCE_SCANS)) ? run_cnt_reg :
                    run_cnt_reg + RUN_W'(1);
  assign accept   = frame_tick && (run_next == RUN_W'(DEBOUNCE_SCANS)) &&
                    (frame_res.kind != FR_MULTI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_meta_reg     <= '1;
      rows_sync_reg     <= '1;
      win_cnt_reg       <= '0;
      col_idx_reg       <= '0;
      acc_cnt_reg       <= '0;
      acc_code_reg      <= '0;
      prev_res_reg.kind <= FR_NONE;
      prev_res_reg.code <= '0;
      run_cnt_reg       <= '0;
    end else begin
      rows_meta_reg <= rows;
      rows_sync_reg <= rows_meta_reg;
      if (sample_tick) begin
        win_cnt_reg <= '0;
        col_idx_reg <= (col_idx_reg == COL_W'(COLS - 1)) ? '0 : col_idx_reg + COL_W'(1);
        if (frame_tick) begin
          acc_cnt_reg  <= '0;
          acc_code_reg <= '0;
          prev_res_reg <= frame_res;
          run_cnt_reg  <= run_next;
        end else begin
          acc_cnt_reg  <= sum_cnt;
          acc_code_reg <= sum_code;
        end
      end else begin
        win_cnt_reg <= win_cnt_reg + WIN_W'(1);
      end
    end
  end

  assign rep_limit = rep_first_reg ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE);

  always_comb begin
    state_next     = state_reg;
    held_code_next = held_code_reg;
    rep_cnt_next   = rep_cnt_reg;
    rep_first_next = rep_first_reg;
    ev_push        = 1'b0;
    ev_code        = held_code_reg;
    if (accept && frame_res.kind == FR_SINGLE &&
        (state_reg == ST_IDLE || frame_res.code != held_code_reg)) begin
      state_next     = ST_HELD;
      held_code_next = frame_res.code;
      ev_push        = 1'b1;
      ev_code        = frame_res.code;
      rep_cnt_next   = '0;
      rep_first_next = 1'b1;
    end else if (accept && frame_res.kind == FR_NONE) begin
      state_next     = ST_IDLE;
      rep_cnt_next   = '0;
      rep_first_next = 1'b1;
    end else if (REPEAT_EN != 0 && frame_tick && state_reg == ST_HELD) begin
      // First repeat after REPEAT_DLY frames, later ones every REPEAT_RATE.
      if (rep_cnt_reg + REP_W'(1) == rep_limit) begin
        ev_push        = 1'b1;
        rep_cnt_next   = '0;
        rep_first_next = 1'b0;
      end else begin
        rep_cnt_next = rep_cnt_reg + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      held_code_reg <= '0;
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      held_code_reg <= held_code_next;
      rep_cnt_reg   <= rep_cnt_next;
      rep_first_reg <= rep_first_next;
    end
  end

  assign key_held = (state_reg == ST_HELD);

  key_event_buf #(.KEY_W(KEY_W)) u_evt_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ev_push),
    .push_code (ev_code),
    .bus       (key_bus),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_keypad_scanner_n.sv
// Scoreboard bench: dut0 without repeat, dut1 with repeat (DLY=4, RATE=2);
// 4x4 keypad, SCAN_DIV=4, DEBOUNCE_SCANS=2 -> 16-cycle frame.
module tb_keypad_scanner_n;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rows0, cols0, rows1, cols1;
  logic        held0, ovf0, held1, ovf1;
  logic [15:0] press0, press1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tcyc    = 0;
  int ev0     = 0;
  int e0;
  int q0[$], q1[$], t1[$];
  int off[6] = '{0, 4, 6, 8, 10, 12};
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic [3:0] exp_cols;
  logic quiet_bad;

  always #5 clk = ~clk;

  keypad_scanner_n_if #(.KEY_W(4)) bus0 ();
  keypad_scanner_n_if #(.KEY_W(4)) bus1 ();

  keypad_scanner_n #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2),
                     .REPEAT_EN(0), .REPEAT_DLY(4), .REPEAT_RATE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rows(rows0), .cols(cols0),
    .key_bus(bus0), .key_held(held0), .overflow(ovf0));

  keypad_scanner_n #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2),
                     .REPEAT_EN(1), .REPEAT_DLY(4), .REPEAT_RATE(2)) u_dut1 (
    .clk(clk), .rows(rows1), .rst_n(rst_n), .cols(cols1),
    .key_bus(bus1), .key_held(held1), .overflow(ovf1));

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows0 = '1;
    rows1 = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press0[r*4+c] && !cols0[c]) rows0[r] = 1'b0;
        if (press1[r*4+c] && !cols1[c]) rows1[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  always @(posedge clk) begin
    tcyc <= tcyc + 1;
    cyc  <= rst_n ? cyc + 1 : 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.key_valid && !pv0) chk("rise_phase0", cyc % FRAME, 0);
      if (bus0.key_valid && bus0.key_ready) begin
        ev0 <= ev0 + 1;
        if (q0.size() == 0) chk("evt0_unexpected", q0.size(), 1);
        else                chk("evt0_code", bus0.key_code, q0.pop_front());
      end
      if (bus1.key_valid && !pv1) chk("rise_phase1", cyc % FRAME, 0);
      if (bus1.key_valid && bus1.key_ready) begin
        t1.push_back(tcyc);
        if (q1.size() == 0) chk("evt1_unexpected", q1.size(), 1);
        else                chk("evt1_code", bus1.key_code, q1.pop_front());
      end
    end
    pv0 <= bus0.key_valid;
    pv1 <= bus1.key_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    press0 = '0;
    press1 = '0;
    bus0.key_ready = 1'b1;
    bus1.key_ready = 1'b1;
    repeat (3) tick();
    chk("rst_cols0", cols0, 4'b1110);
    chk("rst_cols1", cols1, 4'b1110);
    chk("rst_valid0", bus0.key_valid, 0);
    chk("rst_code0", bus0.key_code, 0);
    chk("rst_held0", held0, 0);
    chk("rst_ovf0", ovf0, 0);

    // 1: idle rotation for 10 frames
    rst_n = 1'b1;
    quiet_bad = 1'b0;
    for (int i = 0; i < 10 * FRAME; i++) begin
      exp_cols = ~(4'b0001 << ((i / 4) % 4));
      chk("cols_rot", cols0, exp_cols);
      if (bus0.key_valid || held0 || ovf0 || bus1.key_valid || held1 || ovf1) quiet_bad = 1'b1;
      tick();
    end
    chk("t1_quiet", quiet_bad, 0);

    // 2: single key r1,c2
    e0 = ev0;
    press0[6] = 1'b1;
    q0.push_back(6);
    frames(1);
    chk("t2_held_early", held0, 0);
    for (int i = 0; i < 4 * FRAME && !held0; i++) tick();
    chk("t2_held", held0, 1);
    chk("t2_code", bus0.key_code, 6);
    frames(1);
    chk("t2_one_event", ev0 - e0, 1);
    press0[6] = 1'b0;
    frames(1);
    chk("t2_held_rel1", held0, 1);
    frames(2);
    chk("t2_released", held0, 0);
    chk("t2_no_rel_evt", ev0 - e0, 1);

    // 3: bouncing r0,c0, toggled once per frame so no two frames agree
    e0 = ev0;
    quiet_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      press0[0] = ~press0[0];
      repeat (FRAME) begin
        tick();
        if (held0) quiet_bad = 1'b1;
      end
    end
    frames(3);
    chk("t3_never_held", quiet_bad, 0);
    chk("t3_held", held0, 0);
    chk("t3_no_evt", ev0 - e0, 0);

    // 4: ghost frame (codes 0 and 5), then release 5
    e0 = ev0;
    press0[0] = 1'b1;
    press0[5] = 1'b1;
    frames(8);
    chk("t4_multi_no_evt", ev0 - e0, 0);
    chk("t4_multi_held", held0, 0);
    press0[5] = 1'b0;
    q0.push_back(0);
    frames(1);
    chk("t4_held_early", held0, 0);
    for (int i = 0; i < 3 * FRAME && !held0; i++) tick();
    chk("t4_held", held0, 1);
    chk("t4_code", bus0.key_code, 0);
    frames(1);
    chk("t4_one_event", ev0 - e0, 1);
    press0[0] = 1'b0;
    frames(3);
    chk("t4_released", held0, 0);

    // 5: consumer stalled -> second press dropped, overflow sticks
    bus0.key_ready = 1'b0;
    press0[3] = 1'b1;
    q0.push_back(3);
    for (int i = 0; i < 4 * FRAME && !bus0.key_valid; i++) tick();
    chk("t5_valid", bus0.key_valid, 1);
    press0[3] = 1'b0;
    frames(3);
    chk("t5_rel_held", held0, 0);
    press0[9] = 1'b1;
    frames(4);
    chk("t5_held9", held0, 1);
    chk("t5_code_kept", bus0.key_code, 3);
    chk("t5_valid_kept", bus0.key_valid, 1);
    chk("t5_overflow", ovf0, 1);
    bus0.key_ready = 1'b1;
    tick();
    bus0.key_ready = 1'b0;
    chk("t5_valid_drop", bus0.key_valid, 0);
    chk("t5_ovf_sticky", ovf0, 1);
    press0[9] = 1'b0;
    bus0.key_ready = 1'b1;
    frames(3);

    // 6: auto-repeat on dut1, then reset mid-frame with an event pending
    press1[2] = 1'b1;
    repeat (6) q1.push_back(2);
    for (int i = 0; i < 20 * FRAME && t1.size() < 6; i++) tick();
    chk("t6_events", t1.size(), 6);
    if (t1.size() >= 6) begin
      for (int i = 1; i < 6; i++) chk($sformatf("t6_gap%0d", i), t1[i] - t1[0], off[i] * FRAME);
    end
    bus1.key_ready = 1'b0;
    for (int i = 0; i < 4 * FRAME && !bus1.key_valid; i++) tick();
    chk("t6_pend_valid", bus1.key_valid, 1);
    repeat (5) tick();
    chk("t6_pend_held", held1, 1);
    chk("t6_pend_code", bus1.key_code, 2);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_cols", cols1, 4'b1110);
    chk("t6_rst_valid", bus1.key_valid, 0);
    chk("t6_rst_code", bus1.key_code, 0);
    chk("t6_rst_held", held1, 0);
    chk("t6_rst_ovf1", ovf1, 0);
    chk("t6_rst_ovf0", ovf0, 0);
    rst_n = 1'b1;
    press1 = '0;
    bus1.key_ready = 1'b1;
    frames(3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
